// File: rtl/feature_read_sched_if.sv
`default_nettype none
`timescale 1ns/1ps
// feature_read_sched_if: control, FIFO-side and pixel-output signals of the frame read scheduler.
// Revision 1.0
interface feature_read_sched_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 27,
  parameter int IMG_H  = 27
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic              start;
  logic              busy;
  logic              done;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;
  logic              out_win;

  modport master (
    input  start, fifo_valid, fifo_data, out_ready,
    output busy, done, fifo_rd_en, out_valid, out_data, out_row, out_col,
           out_sof, out_eol, out_eof, out_win
  );

  modport slave (
    output start, fifo_valid, fifo_data, out_ready,
    input  busy, done, fifo_rd_en, out_valid, out_data, out_row, out_col,
           out_sof, out_eol, out_eof, out_win
  );
endinterface
`default_nettype wire

// File: rtl/feature_read_sched.sv
`default_nettype none
`timescale 1ns/1ps
// feature_read_sched: drains one raster frame from a FWFT FIFO into a tagged valid/ready stage.
// Revision 1.0
module feature_read_sched #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 27,
  parameter int IMG_H  = 27,
  parameter int KERNEL = 3,
  parameter int STRIDE = 1
) (
  input logic                  clk,
  input logic                  rst,
  feature_read_sched_if.master bus
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_K    = ROW_W'(KERNEL - 1);
  localparam logic [COL_W-1:0] COL_K    = COL_W'(KERNEL - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STRIDE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [PH_W-1:0]   row_phase;
  logic [PH_W-1:0]   col_phase;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic [ROW_W-1:0]  pix_row;
  logic [COL_W-1:0]  pix_col;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_eof;
  logic              pix_win;
  logic              load;
  logic              accept;
  logic              last_pix;
  logic              win_now;

  assign load     = (state == S_RUN) & bus.fifo_valid & (~pix_valid | bus.out_ready);
  assign accept   = pix_valid & bus.out_ready;
  assign last_pix = (row == ROW_LAST) & (col == COL_LAST);
  assign win_now  = (row >= ROW_K) & (col >= COL_K) & (row_phase == '0) & (col_phase == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      row_phase <= '0;
      col_phase <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_row   <= '0;
      pix_col   <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      pix_win   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_RUN;
            row       <= '0;
            col       <= '0;
            row_phase <= '0;
            col_phase <= '0;
          end
        end
        S_RUN:   if (load && last_pix) state <= S_FLUSH;
        S_FLUSH: if (accept) state <= S_DONE;
        default: state <= S_IDLE;
      endcase

      if (load) begin
        pix_valid <= 1'b1;
        pix_data  <= bus.fifo_data;
        pix_row   <= row;
        pix_col   <= col;
        pix_sof   <= (row == '0) & (col == '0);
        pix_eol   <= (col == COL_LAST);
        pix_eof   <= last_pix;
        pix_win   <= win_now;
        if (col == COL_LAST) begin
          col       <= '0;
          col_phase <= '0;
          if (row != ROW_LAST) begin
            row <= row + ROW_W'(1);
            // Row phase only starts counting once the first full window row is reached.
            if (row >= ROW_K)
              row_phase <= (row_phase == PH_LAST) ? '0 : row_phase + PH_W'(1);
          end
        end else begin
          col <= col + COL_W'(1);
          if (col >= COL_K)
            col_phase <= (col_phase == PH_LAST) ? '0 : col_phase + PH_W'(1);
        end
      end else if (accept) begin
        pix_valid <= 1'b0;
      end
    end
  end

  assign bus.fifo_rd_en = load;
  assign bus.busy       = (state == S_RUN) | (state == S_FLUSH);
  assign bus.done       = (state == S_DONE);
  assign bus.out_valid  = pix_valid;
  assign bus.out_data   = pix_data;
  assign bus.out_row    = pix_row;
  assign bus.out_col    = pix_col;
  assign bus.out_sof    = pix_sof;
  assign bus.out_eol    = pix_eol;
  assign bus.out_eof    = pix_eof;
  assign bus.out_win    = pix_win;
endmodule
`default_nettype wire
